// File: rtl/store_buffer_if.sv
// Store buffer port bundle: MEM-stage store/load requests
// on one side, data-memory write port and stalls on the other.
interface store_buffer_if;
   logic        StValid;
   logic [31:0] StAddr;
   logic [31:0] StData;
   logic [2:0]  StType;
   logic [31:0] StPC4;
   logic        LdReq;
   logic [31:0] LdAddr;
   logic [31:0] DMAddr;
   logic [31:0] DMIn;
   logic [2:0]  StoreType;
   logic        MemWr;
   logic [31:0] PC4;
   logic        StStall;
   logic        LdStall;
   logic        Empty;

   modport master (
      output StValid, StAddr, StData, StType, StPC4,
      output LdReq, LdAddr,
      input  DMAddr, DMIn, StoreType, MemWr, PC4,
      input  StStall, LdStall, Empty
   );

   modport slave (
      input  StValid, StAddr, StData, StType, StPC4,
      input  LdReq, LdAddr,
      output DMAddr, DMIn, StoreType, MemWr, PC4,
      output StStall, LdStall, Empty
   );
endinterface

// File: rtl/store_buffer.sv
// Store write buffer: FIFO of committed stores drained into
// data memory when the port is free, with load-hazard stalls.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int PTRW  = 2
) (
   input  logic          clk,
   input  logic          reset,
   store_buffer_if.slave bus
);

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  typ;
      logic [31:0] pc4;
   } entry_t;

   entry_t           ent_q [DEPTH];
   entry_t           ent_d [DEPTH];
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [PTRW-1:0]  head_q, head_d;
   logic [PTRW-1:0]  tail_q, tail_d;
   logic [PTRW:0]    count_q, count_d;
   logic             full;
   logic             push;
   logic             pop;
   logic             match;
   logic             ld_serve;
   entry_t           head_ent;

   // Word-granular hazard search and stall outputs
   always_comb begin
      match = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i] &&
             ent_q[i].addr[31:2] == bus.LdAddr[31:2])
            match = 1'b1;
      end
      full        = (count_q == (PTRW+1)'(DEPTH));
      bus.LdStall = bus.LdReq && match;
      bus.StStall = bus.StValid && full;
      bus.Empty   = (count_q == '0);
      push        = bus.StValid && !full;
   end

   // Memory port arbitration: a clean load wins, else drain head
   always_comb begin
      head_ent      = ent_q[head_q];
      ld_serve      = bus.LdReq && !bus.LdStall;
      pop           = !ld_serve && (count_q != '0);
      bus.MemWr     = 1'b0;
      bus.DMAddr    = bus.LdAddr;
      bus.DMIn      = '0;
      bus.StoreType = 3'b011;
      bus.PC4       = '0;
      if (pop) begin
         bus.MemWr     = 1'b1;
         bus.DMAddr    = head_ent.addr;
         bus.DMIn      = head_ent.data;
         bus.StoreType = head_ent.typ;
         bus.PC4       = head_ent.pc4;
      end
   end

   // Next FIFO state: pop at head, push at tail
   always_comb begin
      ent_d   = ent_q;
      vld_d   = vld_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (pop) begin
         vld_d[head_q] = 1'b0;
         head_d        = head_q + PTRW'(1);
      end
      if (push) begin
         ent_d[tail_q].addr = bus.StAddr;
         ent_d[tail_q].data = bus.StData;
         ent_d[tail_q].typ  = bus.StType;
         ent_d[tail_q].pc4  = bus.StPC4;
         vld_d[tail_q]      = 1'b1;
         tail_d             = tail_q + PTRW'(1);
      end
      if (push && !pop)
         count_d = count_q + (PTRW+1)'(1);
      else if (pop && !push)
         count_d = count_q - (PTRW+1)'(1);
   end

   // State registers; reset discards every pending store
   always_ff @(posedge clk) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         vld_q   <= '0;
      end else begin
         ent_q   <= ent_d;
         vld_q   <= vld_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed vector
// table plus random traffic against a queue-based model.
module tb_store_buffer;

   localparam int DEPTH = 4;

   logic clk;
   logic reset;

   store_buffer_if bif ();

   store_buffer #(
      .DEPTH (DEPTH),
      .PTRW  (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        rst_n;
      logic        st_valid;
      logic [31:0] st_addr;
      logic [31:0] st_data;
      logic [2:0]  st_type;
      logic [31:0] st_pc4;
      logic        ld_req;
      logic [31:0] ld_addr;
      bit          chk;
      logic        e_wr;
      logic [31:0] e_addr;
      logic [31:0] e_din;
      logic [2:0]  e_ty;
      logic [31:0] e_pc;
      logic        e_ls;
      logic        e_ss;
      logic        e_em;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  ty;
      logic [31:0] pc4;
   } ment_t;

   vec_t  tbl [$];
   ment_t mq [$];
   int    errors = 0;
   int    checks = 0;

   task automatic check(input string nm,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic add(
      input logic rst, input logic sv,
      input logic [31:0] sa, input logic [31:0] sd,
      input logic [2:0] sty, input logic [31:0] spc,
      input logic lr, input logic [31:0] la, input bit chk,
      input logic ewr, input logic [31:0] eaddr,
      input logic [31:0] edin, input logic [2:0] ety,
      input logic [31:0] epc, input logic els,
      input logic ess, input logic eem);
      vec_t v;
      v.rst_n = rst;   v.st_valid = sv;
      v.st_addr = sa;  v.st_data = sd;
      v.st_type = sty; v.st_pc4 = spc;
      v.ld_req = lr;   v.ld_addr = la;
      v.chk = chk;     v.e_wr = ewr;
      v.e_addr = eaddr; v.e_din = edin;
      v.e_ty = ety;    v.e_pc = epc;
      v.e_ls = els;    v.e_ss = ess;
      v.e_em = eem;
      tbl.push_back(v);
   endtask

   // One clock: drive, compare mid-cycle, advance the model at the edge
   task automatic run_cycle(input vec_t v, input bit use_tbl);
      logic        hit, m_ls, m_ss, m_em, m_wr, m_dat;
      logic [31:0] m_addr, m_din, m_pc;
      logic [2:0]  m_ty;
      reset       = v.rst_n;
      bif.StValid = v.st_valid;
      bif.StAddr  = v.st_addr;
      bif.StData  = v.st_data;
      bif.StType  = v.st_type;
      bif.StPC4   = v.st_pc4;
      bif.LdReq   = v.ld_req;
      bif.LdAddr  = v.ld_addr;
      #2;
      hit = 1'b0;
      foreach (mq[i])
         if (mq[i].addr[31:2] == v.ld_addr[31:2]) hit = 1'b1;
      m_ls = v.ld_req && hit;
      m_ss = v.st_valid && (mq.size() == DEPTH);
      m_em = (mq.size() == 0);
      m_wr = 1'b0; m_dat = 1'b1;
      m_addr = v.ld_addr; m_din = 0; m_ty = 3'b011; m_pc = 0;
      if (v.ld_req && !m_ls) begin
         m_dat = 1'b0;
      end else if (mq.size() > 0) begin
         m_wr = 1'b1;
         m_addr = mq[0].addr; m_din = mq[0].data;
         m_ty = mq[0].ty;     m_pc = mq[0].pc4;
      end
      if (v.chk) begin
         check("m_MemWr", 32'(bif.MemWr), 32'(m_wr));
         check("m_DMAddr", bif.DMAddr, m_addr);
         check("m_LdStall", 32'(bif.LdStall), 32'(m_ls));
         check("m_StStall", 32'(bif.StStall), 32'(m_ss));
         check("m_Empty", 32'(bif.Empty), 32'(m_em));
         if (m_dat) begin
            check("m_DMIn", bif.DMIn, m_din);
            check("m_StoreType", 32'(bif.StoreType), 32'(m_ty));
            check("m_PC4", bif.PC4, m_pc);
         end
         if (use_tbl) begin
            check("t_MemWr", 32'(bif.MemWr), 32'(v.e_wr));
            check("t_DMAddr", bif.DMAddr, v.e_addr);
            check("t_LdStall", 32'(bif.LdStall), 32'(v.e_ls));
            check("t_StStall", 32'(bif.StStall), 32'(v.e_ss));
            check("t_Empty", 32'(bif.Empty), 32'(v.e_em));
            if (v.e_wr) begin
               check("t_DMIn", bif.DMIn, v.e_din);
               check("t_StoreType", 32'(bif.StoreType),
                     32'(v.e_ty));
               check("t_PC4", bif.PC4, v.e_pc);
            end
         end
      end
      @(posedge clk);
      if (!v.rst_n) begin
         mq.delete();
      end else begin
         if (m_wr) void'(mq.pop_front());
         if (v.st_valid && !m_ss)
            mq.push_back('{v.st_addr, v.st_data,
                           v.st_type, v.st_pc4});
      end
      #1;
   endtask

   initial begin
      vec_t v;
      int   tsel;
      // reset hold with a store presented
      add(0,1,'h500,'hAAAAAAAA,3,'h1004,0,0,0, 0,0,0,3,0,0,0,1);
      add(0,1,'h500,'hAAAAAAAA,3,'h1004,0,0,1, 0,0,0,3,0,0,0,1);
      add(1,0,0,0,3,0,0,0,1, 0,0,0,3,0,0,0,1);
      // single store then drain
      add(1,1,'h10,'h12345678,3,'h3004,0,0,1, 0,0,0,3,0,0,0,1);
      add(1,0,0,0,3,0,0,0,1,
          1,'h10,'h12345678,3,'h3004,0,0,0);
      add(1,0,0,0,3,0,0,0,1, 0,0,0,3,0,0,0,1);
      // fill behind a non-matching load, fifth push stalls
      add(1,1,'h200,1,3,'h2004,1,'h100,1, 0,'h100,0,3,0,0,0,1);
      add(1,1,'h204,2,3,'h2008,1,'h100,1, 0,'h100,0,3,0,0,0,0);
      add(1,1,'h208,3,3,'h200C,1,'h100,1, 0,'h100,0,3,0,0,0,0);
      add(1,1,'h20C,4,3,'h2010,1,'h100,1, 0,'h100,0,3,0,0,0,0);
      add(1,1,'h210,5,3,'h2014,1,'h100,1, 0,'h100,0,3,0,0,1,0);
      add(1,1,'h210,5,3,'h2014,0,0,1, 1,'h200,1,3,'h2004,0,1,0);
      add(1,1,'h210,5,3,'h2014,0,0,1, 1,'h204,2,3,'h2008,0,0,0);
      add(1,0,0,0,3,0,0,0,1, 1,'h208,3,3,'h200C,0,0,0);
      add(1,0,0,0,3,0,0,0,1, 1,'h20C,4,3,'h2010,0,0,0);
      add(1,0,0,0,3,0,0,0,1, 1,'h210,5,3,'h2014,0,0,0);
      add(1,0,0,0,3,0,0,0,1, 0,0,0,3,0,0,0,1);
      // load conflict on word 0x20
      add(1,1,'h21,'hEF,0,'h4004,1,'h100,1, 0,'h100,0,3,0,0,0,1);
      add(1,1,'h40,'hCAFEBABE,3,'h4008,1,'h100,1,
          0,'h100,0,3,0,0,0,0);
      add(1,0,0,0,3,0,1,'h20,1, 1,'h21,'hEF,0,'h4004,1,0,0);
      add(1,0,0,0,3,0,1,'h20,1, 0,'h20,0,3,0,0,0,0);
      add(1,0,0,0,3,0,0,0,1,
          1,'h40,'hCAFEBABE,3,'h4008,0,0,0);
      add(1,0,0,0,3,0,0,0,1, 0,0,0,3,0,0,0,1);
      // reset mid-drain discards pending stores
      add(1,1,'h300,'h11,3,'h5004,1,'h100,1, 0,'h100,0,3,0,0,0,1);
      add(1,1,'h304,'h22,3,'h5008,1,'h100,1, 0,'h100,0,3,0,0,0,0);
      add(1,1,'h308,'h33,3,'h500C,1,'h100,1, 0,'h100,0,3,0,0,0,0);
      add(0,0,0,0,3,0,0,0,1, 1,'h300,'h11,3,'h5004,0,0,0);
      add(1,0,0,0,3,0,0,0,1, 0,0,0,3,0,0,0,1);
      // streaming push/pop across pointer wrap
      add(1,1,'h600,'hD0,3,'h6004,0,0,1, 0,0,0,3,0,0,0,1);
      for (int k = 1; k < 6; k++)
         add(1,1,'h600+4*k,'hD0+k,3,'h6004+4*k,0,0,1,
             1,'h600+4*(k-1),'hD0+k-1,3,'h6004+4*(k-1),0,0,0);
      add(1,0,0,0,3,0,0,0,1, 1,'h614,'hD5,3,'h6018,0,0,0);
      add(1,0,0,0,3,0,0,0,1, 0,0,0,3,0,0,0,1);

      foreach (tbl[i]) run_cycle(tbl[i], 1'b1);

      // random traffic on a small address window
      for (int n = 0; n < 3000; n++) begin
         v = '{default: 0};
         v.rst_n    = ($urandom_range(0, 99) != 0);
         v.st_valid = ($urandom_range(0, 2) != 0);
         v.st_addr  = $urandom_range(0, 63);
         v.st_data  = $urandom;
         tsel       = $urandom_range(0, 2);
         v.st_type  = (tsel == 2) ? 3'b011 : 3'(tsel);
         v.st_pc4   = $urandom;
         v.ld_req   = ($urandom_range(0, 1) != 0);
         v.ld_addr  = $urandom_range(0, 63);
         v.chk      = 1'b1;
         run_cycle(v, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
